// File: rtl/emu_scan_ctrl.sv
// emu_scan_ctrl: host-side pause/scan sequencer. Under a held pause it streams the FF chain,
// then the RAM chain, out to the host (save) or in from the host (load) with valid/ready stalling.
module emu_scan_ctrl #(
   parameter int DATA_W    = 64,
   parameter int FF_CNT_W  = 16,
   parameter int RAM_CNT_W = 20
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pause_req,
   output logic                 pause,
   input  logic                 start,
   input  logic                 mode,
   input  logic [FF_CNT_W-1:0]  ff_words,
   input  logic [RAM_CNT_W-1:0] ram_words,
   output logic                 busy,
   output logic                 done,
   output logic                 cmd_err,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_W-1:0]    in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    out_data,
   output logic                 ff_se,
   output logic [DATA_W-1:0]    ff_di,
   input  logic [DATA_W-1:0]    ff_do,
   output logic                 ram_se,
   output logic                 ram_sd,
   output logic [DATA_W-1:0]    ram_di,
   input  logic [DATA_W-1:0]    ram_do
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FF   = 2'd1,
      S_RAM  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic                 mode_q, mode_d;
   logic [FF_CNT_W-1:0]  ff_left_q, ff_left_d;
   logic [RAM_CNT_W-1:0] ram_left_q, ram_left_d;
   logic                 start_ok_s;
   logic                 beat_s;

   assign start_ok_s = (state_q == S_IDLE) && pause_req && start;
   // A beat is the stream partner's half of the handshake; our half is always offered in FF/RAM.
   assign beat_s     = mode_q ? in_valid : out_ready;

   // State and command registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         mode_q     <= 1'b0;
         ff_left_q  <= '0;
         ram_left_q <= '0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         ff_left_q  <= ff_left_d;
         ram_left_q <= ram_left_d;
      end
   end

   // Next-state and word-counter logic.
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      ff_left_d  = ff_left_q;
      ram_left_d = ram_left_q;
      case (state_q)
         S_IDLE: begin
            if (start_ok_s) begin
               mode_d     = mode;
               ff_left_d  = ff_words;
               ram_left_d = ram_words;
               if (ff_words != '0) begin
                  state_d = S_FF;
               end else if (ram_words != '0) begin
                  state_d = S_RAM;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FF: begin
            if (beat_s) begin
               ff_left_d = ff_left_q - FF_CNT_W'(1);
               if (ff_left_q == FF_CNT_W'(1)) begin
                  state_d = (ram_left_q != '0) ? S_RAM : S_DONE;
               end else begin
                  state_d = S_FF;
               end
            end else begin
               state_d = S_FF;
            end
         end
         S_RAM: begin
            if (beat_s) begin
               ram_left_d = ram_left_q - RAM_CNT_W'(1);
               if (ram_left_q == RAM_CNT_W'(1)) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_RAM;
               end
            end else begin
               state_d = S_RAM;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Stream handshakes and scan-port drive. Save loops ff_do/ram_do back so the chain rotates home.
   always_comb begin
      pause     = pause_req || (state_q != S_IDLE);
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      cmd_err   = start && !start_ok_s;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      ff_se     = 1'b0;
      ff_di     = '0;
      ram_se    = 1'b0;
      ram_sd    = 1'b0;
      ram_di    = '0;
      case (state_q)
         S_FF: begin
            if (mode_q) begin
               in_ready = 1'b1;
               ff_di    = in_data;
               ff_se    = in_valid;
            end else begin
               out_valid = 1'b1;
               out_data  = ff_do;
               ff_di     = ff_do;
               ff_se     = out_ready;
            end
         end
         S_RAM: begin
            ram_sd = mode_q;
            if (mode_q) begin
               in_ready = 1'b1;
               ram_di   = in_data;
               ram_se   = in_valid;
            end else begin
               out_valid = 1'b1;
               out_data  = ram_do;
               ram_di    = ram_do;
               ram_se    = out_ready;
            end
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_emu_scan_ctrl.sv
// Scoreboard bench for emu_scan_ctrl: queue-modelled FF/RAM scan chains, random stream stalls,
// expected scan/done events queued per command and popped by an independent monitor.
module tb_emu_scan_ctrl;
   localparam int DW = 64;
   localparam int FW = 16;
   localparam int RW = 20;

   logic          clk = 1'b0;
   logic          rst, pause_req, start, mode;
   logic [FW-1:0] ff_words;
   logic [RW-1:0] ram_words;
   logic          pause, busy, done, cmd_err;
   logic          in_valid = 1'b0, out_ready = 1'b0;
   logic          in_ready, out_valid;
   logic [DW-1:0] in_data = '0, out_data;
   logic          ff_se, ram_se, ram_sd;
   logic [DW-1:0] ff_di, ram_di;
   logic [DW-1:0] ff_do = '0, ram_do = '0;

   typedef struct {
      int            kind;   // 0 = FF beat, 1 = RAM beat, 2 = done
      logic [DW-1:0] data;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] ff_chain[$], ram_chain[$], load_q[$], fixed_q[$];
   int            checks = 0, failures = 0;
   int            pct = 100;
   bit            cur_mode = 1'b0;
   bit            pend_ff, pend_ram, pend_in;
   logic [DW-1:0] pend_ff_di, pend_ram_di;

   always #5 clk = ~clk;

   emu_scan_ctrl #(.DATA_W(DW), .FF_CNT_W(FW), .RAM_CNT_W(RW)) dut (
      .clk(clk), .rst(rst), .pause_req(pause_req), .pause(pause), .start(start), .mode(mode),
      .ff_words(ff_words), .ram_words(ram_words), .busy(busy), .done(done), .cmd_err(cmd_err),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .ff_se(ff_se), .ff_di(ff_di), .ff_do(ff_do),
      .ram_se(ram_se), .ram_sd(ram_sd), .ram_di(ram_di), .ram_do(ram_do)
   );

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // Monitor: sample mid-cycle, pop the scoreboard on every scan beat or done pulse.
   always @(negedge clk) begin
      exp_t e;
      int   ka;
      pend_ff  = 1'b0;
      pend_ram = 1'b0;
      pend_in  = 1'b0;
      if (!rst) begin
         pend_ff     = ff_se;
         pend_ff_di  = ff_di;
         pend_ram    = ram_se;
         pend_ram_di = ram_di;
         pend_in     = in_valid && in_ready;
         if (busy)
            chk("scan_vs_handshake", DW'(ff_se || ram_se),
                DW'(cur_mode ? (in_valid && in_ready) : (out_valid && out_ready)));
         if (ff_se || ram_se || done) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_event actual=ff_se:%b,ram_se:%b,done:%b required=none", ff_se, ram_se, done);
            end else begin
               e  = exp_q.pop_front();
               ka = done ? 2 : (ram_se ? 1 : 0);
               chk("event_kind", DW'(ka), DW'(e.kind));
               chk("single_event", DW'(32'(ff_se) + 32'(ram_se) + 32'(done)), DW'(1));
               if (e.kind != 2) begin
                  chk("scan_di", ff_se ? ff_di : ram_di, e.data);
                  if (!cur_mode) chk("out_data", out_data, e.data);
                  if (ram_se) chk("ram_sd", DW'(ram_sd), DW'(cur_mode));
               end
            end
         end
      end
   end

   // Chain model and stream partner: shift chains on recorded beats, then redraw stalls.
   always @(posedge clk) begin
      bit vr;
      #1;
      if (pend_ff) begin
         ff_chain.push_back(pend_ff_di);
         void'(ff_chain.pop_front());
      end
      if (pend_ram) begin
         ram_chain.push_back(pend_ram_di);
         void'(ram_chain.pop_front());
      end
      if (pend_in && load_q.size() > 0) void'(load_q.pop_front());
      ff_do  = (ff_chain.size() > 0) ? ff_chain[0] : '0;
      ram_do = (ram_chain.size() > 0) ? ram_chain[0] : '0;
      if (pct < 0) begin
         out_ready = ~out_ready;
         vr        = out_ready;
      end else begin
         out_ready = ($urandom_range(99) < 32'(pct));
         vr        = ($urandom_range(99) < 32'(pct));
      end
      in_valid = (load_q.size() > 0) && vr;
      in_data  = (load_q.size() > 0) ? load_q[0] : '0;
   end

   task automatic do_cmd(input bit md, input int ffw, input int ramw, input int rate,
                         input int err_at, input int rst_at, input bit drop_pause);
      logic [DW-1:0] words[$];
      logic [DW-1:0] want_ff[$], want_ram[$];
      int  n = ffw + ramw;
      int  last_k = 0;
      bit  seen_done = 1'b0;
      @(posedge clk);
      #2;
      pct      = rate;
      cur_mode = md;
      ff_chain.delete(); ram_chain.delete(); load_q.delete(); exp_q.delete();
      for (int i = 0; i < ffw; i++) ff_chain.push_back({$urandom, $urandom});
      for (int i = 0; i < ramw; i++) ram_chain.push_back({$urandom, $urandom});
      if (md) begin
         if (fixed_q.size() == n) words = fixed_q;
         else for (int i = 0; i < n; i++) words.push_back({$urandom, $urandom});
         fixed_q.delete();
         load_q = words;
         for (int i = 0; i < n; i++) exp_q.push_back('{(i < ffw) ? 0 : 1, words[i]});
         for (int i = 0; i < ffw; i++) want_ff.push_back(words[i]);
         for (int i = 0; i < ramw; i++) want_ram.push_back(words[ffw+i]);
      end else begin
         want_ff  = ff_chain;
         want_ram = ram_chain;
         foreach (want_ff[i]) exp_q.push_back('{0, want_ff[i]});
         foreach (want_ram[i]) exp_q.push_back('{1, want_ram[i]});
      end
      exp_q.push_back('{2, '0});
      pause_req = 1'b1;
      start     = 1'b1;
      mode      = md;
      ff_words  = FW'(ffw);
      ram_words = RW'(ramw);
      @(negedge clk);
      chk("accept_cmd_err", DW'(cmd_err), DW'(0));
      chk("accept_cycle_idle", DW'(busy), DW'(0));
      @(posedge clk);
      #2;
      start     = 1'b0;
      mode      = ~md;
      ff_words  = FW'($urandom);
      ram_words = RW'($urandom);
      if (drop_pause) pause_req = 1'b0;
      for (int k = 1; k <= 3000 && !seen_done; k++) begin
         if (k == rst_at) begin
            rst = 1'b1;
            #1;
            chk("rst_busy", DW'(busy), DW'(0));
            chk("rst_done", DW'(done), DW'(0));
            chk("rst_cmd_err", DW'(cmd_err), DW'(0));
            chk("rst_ff_se", DW'(ff_se), DW'(0));
            chk("rst_ram_se", DW'(ram_se), DW'(0));
            chk("rst_out_valid", DW'(out_valid), DW'(0));
            chk("rst_in_ready", DW'(in_ready), DW'(0));
            chk("rst_ram_sd", DW'(ram_sd), DW'(0));
            chk("rst_pause_hi", DW'(pause), DW'(1));
            pause_req = 1'b0;
            #1;
            chk("rst_pause_lo", DW'(pause), DW'(0));
            exp_q.delete();
            load_q.delete();
            repeat (2) @(posedge clk);
            #2;
            rst       = 1'b0;
            pause_req = 1'b1;
            return;
         end
         if (k == err_at) begin
            start = 1'b1;
            #1;
            chk("busy_start_cmd_err", DW'(cmd_err), DW'(1));
         end
         @(negedge clk);
         if (k == err_at) start = 1'b0;
         chk("busy_in_cmd", DW'(busy), DW'(1));
         chk("pause_held", DW'(pause), DW'(1));
         if (ff_se || ram_se) last_k = k;
         if (done) begin
            seen_done = 1'b1;
            chk("done_after_last_beat", DW'(k), DW'((n == 0) ? 1 : last_k + 1));
            if (rate == 100) chk("done_latency", DW'(k), DW'(n + 1));
         end
         @(posedge clk);
         #2;
      end
      if (!seen_done) begin
         checks++;
         failures++;
         $display("FAIL done_timeout actual=no_done required=done_within_3000_cycles");
      end
      @(negedge clk);
      chk("idle_busy", DW'(busy), DW'(0));
      chk("idle_done", DW'(done), DW'(0));
      chk("idle_pause", DW'(pause), DW'(drop_pause ? 0 : 1));
      chk("scoreboard_drained", DW'(exp_q.size()), DW'(0));
      chk("ff_chain_len", DW'(ff_chain.size()), DW'(want_ff.size()));
      chk("ram_chain_len", DW'(ram_chain.size()), DW'(want_ram.size()));
      for (int i = 0; i < ffw && i < ff_chain.size(); i++) chk("ff_chain_word", ff_chain[i], want_ff[i]);
      for (int i = 0; i < ramw && i < ram_chain.size(); i++) chk("ram_chain_word", ram_chain[i], want_ram[i]);
      pause_req = 1'b1;
   endtask

   initial begin
      rst       = 1'b1;
      pause_req = 1'b0;
      start     = 1'b0;
      mode      = 1'b0;
      ff_words  = '0;
      ram_words = '0;
      repeat (2) @(posedge clk);
      #2;
      chk("reset_busy", DW'(busy), DW'(0));
      chk("reset_done", DW'(done), DW'(0));
      chk("reset_scan_en", DW'(ff_se || ram_se), DW'(0));
      chk("reset_streams", DW'(out_valid || in_ready), DW'(0));
      chk("reset_ram_sd", DW'(ram_sd), DW'(0));
      chk("reset_pause_lo", DW'(pause), DW'(0));
      pause_req = 1'b1;
      #1;
      chk("reset_pause_hi", DW'(pause), DW'(1));
      rst = 1'b0;

      // start without pause_req is rejected
      @(posedge clk);
      #2;
      pause_req = 1'b0;
      start     = 1'b1;
      #1;
      chk("nopause_cmd_err", DW'(cmd_err), DW'(1));
      @(posedge clk);
      #2;
      start = 1'b0;
      @(negedge clk);
      chk("nopause_busy", DW'(busy), DW'(0));
      chk("nopause_err_pulse", DW'(cmd_err), DW'(0));
      chk("nopause_no_done", DW'(done), DW'(0));
      pause_req = 1'b1;

      do_cmd(1'b0, 3, 2, 100, -1, -1, 1'b0);
      do_cmd(1'b0, 3, 2, -1, -1, -1, 1'b0);
      fixed_q = '{64'hA, 64'hB, 64'hC};
      do_cmd(1'b1, 2, 1, 100, -1, -1, 1'b0);
      do_cmd(1'b0, 3, 2, 100, 2, -1, 1'b1);
      do_cmd(1'b0, 0, 0, 100, -1, -1, 1'b0);
      do_cmd(1'b0, 0, 4, 100, -1, -1, 1'b0);
      do_cmd(1'b1, 0, 4, 100, -1, -1, 1'b0);
      do_cmd(1'b0, 3, 2, 100, -1, 3, 1'b0);
      do_cmd(1'b0, 3, 2, 100, -1, -1, 1'b0);
      for (int r = 0; r < 12; r++)
         do_cmd(1'($urandom), int'($urandom_range(6)), int'($urandom_range(6)),
                int'($urandom_range(30, 100)), -1, -1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
